// File: rtl/bp_me_outstanding_limiter.sv
// Purpose: credit limiter on the core->memory command path with hang/underflow detection and stats.
// Latency: zero; command valid/ready/payload pass through combinationally, only gated.
// Backpressure: fifo ready passes through; the command is held back when credits run out or after an error.
module bp_me_outstanding_limiter #(
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 4,
  parameter int timeout_cycles_p  = 1024
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,

  input  logic [msg_width_p-1:0] mem_cmd_i,
  input  logic                   mem_cmd_v_i,
  output logic                   mem_cmd_ready_o,

  output logic [msg_width_p-1:0] mem_cmd_o,
  output logic                   mem_cmd_v_o,
  input  logic                   mem_cmd_ready_i,

  input  logic                   mem_resp_v_i,
  input  logic                   mem_resp_yumi_i,

  output logic [7:0]             outstanding_o,
  output logic                   stall_o,
  output logic                   timeout_o,
  output logic                   underflow_o,
  output logic [31:0]            cmd_count_o,
  output logic [31:0]            resp_count_o
);

  // Age must be able to hold timeout_cycles_p itself, the value it lands on when the timeout fires.
  localparam int         AgeW     = $clog2(timeout_cycles_p + 1);
  localparam logic [AgeW-1:0] AgeLast = AgeW'(timeout_cycles_p - 1);
  localparam logic [7:0] MaxOut   = 8'(max_outstanding_p);

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_full  = 2'd1,
    e_error = 2'd2
  } state_e;

  state_e            state_q,       state_d;
  logic [7:0]        outstanding_q, outstanding_d;
  logic [AgeW-1:0]   age_q,         age_d;
  logic              timeout_q,     timeout_d;
  logic              underflow_q,   underflow_d;
  logic [31:0]       cmd_count_q,   cmd_count_d;
  logic [31:0]       resp_count_q,  resp_count_d;

  logic              retire;
  logic              open_w;
  logic              accept;

  // Payload is never touched; it is a straight wire to the fifo.
  assign mem_cmd_o = mem_cmd_i;

  // Combinational gating: at max a same-cycle retirement frees the credit the new command needs.
  always_comb begin
    retire          = mem_resp_v_i & mem_resp_yumi_i;
    open_w          = (state_q == e_run) | ((state_q == e_full) & retire);
    mem_cmd_v_o     = mem_cmd_v_i & open_w;
    mem_cmd_ready_o = mem_cmd_ready_i & open_w;
    stall_o         = mem_cmd_v_i & ~open_w;
    accept          = mem_cmd_v_o & mem_cmd_ready_i;
  end

  // Next-state: credit count, FSM, age watchdog, stickies and saturating statistics.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q;
    age_d         = age_q;
    timeout_d     = timeout_q;
    underflow_d   = underflow_q;
    cmd_count_d   = cmd_count_q;
    resp_count_d  = resp_count_q;

    // Retired responses are always counted, in every state.
    if (retire && (resp_count_q != 32'hFFFF_FFFF)) begin
      resp_count_d = resp_count_q + 32'd1;
    end

    if (state_q == e_error) begin
      // Gate is shut, so only retirements move the count; floor at zero, age frozen.
      if (retire && (outstanding_q != 8'd0)) begin
        outstanding_d = outstanding_q - 8'd1;
      end
    end else begin
      if (accept && (cmd_count_q != 32'hFFFF_FFFF)) begin
        cmd_count_d = cmd_count_q + 32'd1;
      end

      if (retire && (outstanding_q == 8'd0) && !accept) begin
        // A response with nothing in flight means the protocol has been violated.
        underflow_d = 1'b1;
        state_d     = e_error;
      end else begin
        if (accept && !retire) begin
          outstanding_d = outstanding_q + 8'd1;
        end else if (retire && !accept) begin
          outstanding_d = outstanding_q - 8'd1;
        end
        state_d = (outstanding_d == MaxOut) ? e_full : e_run;
      end

      // Watchdog: any retirement or an empty pipe restarts the age; otherwise it climbs to timeout.
      if (retire || (outstanding_q == 8'd0)) begin
        age_d = '0;
      end else begin
        age_d = age_q + AgeW'(1);
        if (age_q == AgeLast) begin
          timeout_d = 1'b1;
          state_d   = e_error;
        end
      end
    end
  end

  // State registers, all cleared immediately by the asynchronous reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= e_run;
      outstanding_q <= 8'd0;
      age_q         <= '0;
      timeout_q     <= 1'b0;
      underflow_q   <= 1'b0;
      cmd_count_q   <= 32'd0;
      resp_count_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      age_q         <= age_d;
      timeout_q     <= timeout_d;
      underflow_q   <= underflow_d;
      cmd_count_q   <= cmd_count_d;
      resp_count_q  <= resp_count_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign timeout_o     = timeout_q;
  assign underflow_o   = underflow_q;
  assign cmd_count_o   = cmd_count_q;
  assign resp_count_o  = resp_count_q;

endmodule

// File: tb/tb_bp_me_outstanding_limiter.sv
// Bench for bp_me_outstanding_limiter: directed scenarios then randomized traffic against a count-level model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, well away from the rising edge.
// The model tracks in-flight count, error/sticky flags, age and statistics as plain integers.
module tb_bp_me_outstanding_limiter;

  localparam int W   = 128;
  localparam int MAX = 4;
  localparam int TO  = 16;

  logic          clk_i;
  logic          reset_n_i;
  logic [W-1:0]  mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [W-1:0]  mem_cmd_o;
  logic          mem_cmd_v_o;
  logic          mem_cmd_ready_i;
  logic          mem_resp_v_i;
  logic          mem_resp_yumi_i;
  logic [7:0]    outstanding_o;
  logic          stall_o;
  logic          timeout_o;
  logic          underflow_o;
  logic [31:0]   cmd_count_o;
  logic [31:0]   resp_count_o;

  bp_me_outstanding_limiter #(
    .msg_width_p      (W),
    .max_outstanding_p(MAX),
    .timeout_cycles_p (TO)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .mem_cmd_i      (mem_cmd_i),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_cmd_ready_o(mem_cmd_ready_o),
    .mem_cmd_o      (mem_cmd_o),
    .mem_cmd_v_o    (mem_cmd_v_o),
    .mem_cmd_ready_i(mem_cmd_ready_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_yumi_i(mem_resp_yumi_i),
    .outstanding_o  (outstanding_o),
    .stall_o        (stall_o),
    .timeout_o      (timeout_o),
    .underflow_o    (underflow_o),
    .cmd_count_o    (cmd_count_o),
    .resp_count_o   (resp_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int     m_out;
  int     m_age;
  bit     m_err;
  bit     m_to;
  bit     m_uf;
  longint m_cc;
  longint m_rc;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_age = 0; m_err = 0; m_to = 0; m_uf = 0; m_cc = 0; m_rc = 0;
  endtask

  // Whether the core's command may pass this cycle, from the model's view
  function automatic bit m_open();
    bit ret;
    ret = mem_resp_v_i && mem_resp_yumi_i;
    return !m_err && ((m_out < MAX) || ret);
  endfunction

  task automatic check_all(input string tag);
    bit op;
    op = m_open();
    chk({tag, ".cmd_o"},  mem_cmd_o,       mem_cmd_i);
    chk({tag, ".v_o"},    mem_cmd_v_o,     W'(mem_cmd_v_i && op));
    chk({tag, ".rdy_o"},  mem_cmd_ready_o, W'(mem_cmd_ready_i && op));
    chk({tag, ".stall"},  stall_o,         W'(mem_cmd_v_i && !op));
    chk({tag, ".out"},    outstanding_o,   W'(m_out));
    chk({tag, ".to"},     timeout_o,       W'(m_to));
    chk({tag, ".uf"},     underflow_o,     W'(m_uf));
    chk({tag, ".ccnt"},   cmd_count_o,     W'(m_cc));
    chk({tag, ".rcnt"},   resp_count_o,    W'(m_rc));
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_clock();
    bit ret, acc;
    int old_out;
    ret = mem_resp_v_i && mem_resp_yumi_i;
    acc = mem_cmd_v_i && m_open() && mem_cmd_ready_i;
    old_out = m_out;
    if (ret) m_rc = (m_rc == 64'hFFFF_FFFF) ? m_rc : m_rc + 1;
    if (m_err) begin
      if (ret && m_out > 0) m_out = m_out - 1;
    end else begin
      if (acc) m_cc = (m_cc == 64'hFFFF_FFFF) ? m_cc : m_cc + 1;
      if (ret && m_out == 0 && !acc) begin
        m_uf = 1; m_err = 1;
      end else begin
        m_out = m_out + int'(acc) - int'(ret);
      end
      if (ret || old_out == 0) m_age = 0;
      else if (m_age == TO - 1) begin
        m_to = 1; m_err = 1; m_age = TO;
      end else m_age = m_age + 1;
    end
  endtask

  task automatic step(input string tag, input bit cv, input logic [W-1:0] cd, input bit fr,
                      input bit rv, input bit ry);
    @(negedge clk_i);
    mem_cmd_v_i = cv; mem_cmd_i = cd; mem_cmd_ready_i = fr;
    mem_resp_v_i = rv; mem_resp_yumi_i = ry;
    #1;
    check_all(tag);
    @(posedge clk_i);
    model_clock();
  endtask

  // Reset applied on the falling edge so its effect is seen without any rising edge
  task automatic do_reset(input string tag);
    @(negedge clk_i);
    reset_n_i = 1'b0;
    mem_cmd_v_i = 0; mem_cmd_ready_i = 0; mem_resp_v_i = 0; mem_resp_yumi_i = 0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_cmd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    reset_n_i = 1'b1;
    mem_cmd_i = '0;
    mem_cmd_v_i = 0; mem_cmd_ready_i = 0; mem_resp_v_i = 0; mem_resp_yumi_i = 0;
    model_reset();
    #2;

    // Reset state
    do_reset("rst0");
    chk("rst0.out_zero", outstanding_o, 0);

    // Fill to max, then the fifth command is stalled
    for (int i = 0; i < MAX; i++) step("fill", 1, rnd_cmd(), 1, 0, 0);
    #2;
    chk("fill.out_max", outstanding_o, MAX);
    step("fifth", 1, rnd_cmd(), 1, 0, 0);

    // At max: command plus retirement in the same cycle
    step("bypass", 1, rnd_cmd(), 1, 1, 1);
    #2;
    chk("bypass.out", outstanding_o, MAX);
    chk("bypass.ccnt", cmd_count_o, MAX + 1);
    chk("bypass.rcnt", resp_count_o, 1);

    // Free a credit, then the fifo refuses
    step("drain1", 0, rnd_cmd(), 1, 1, 1);
    step("fifo_busy", 1, rnd_cmd(), 0, 0, 0);
    #2;
    chk("fifo_busy.out", outstanding_o, MAX - 1);

    // Mid-stream reset with three in flight, then normal acceptance
    do_reset("midrst");
    chk("midrst.ccnt_zero", cmd_count_o, 0);
    step("post_rst", 1, rnd_cmd(), 1, 0, 0);
    step("post_rst2", 0, rnd_cmd(), 1, 0, 0);

    // Underflow
    do_reset("rst_uf");
    step("uf_pulse", 0, rnd_cmd(), 1, 1, 1);
    #2;
    chk("uf.flag", underflow_o, 1);
    step("uf_blocked", 1, rnd_cmd(), 1, 0, 0);
    step("uf_blocked2", 1, rnd_cmd(), 1, 1, 1);

    // Timeout after 16 idle cycles with one command in flight
    do_reset("rst_to");
    step("to_cmd", 1, rnd_cmd(), 1, 0, 0);
    for (int i = 0; i < TO - 1; i++) step("to_wait", 0, rnd_cmd(), 1, 0, 0);
    #2;
    chk("to.before", timeout_o, 0);
    step("to_last", 0, rnd_cmd(), 1, 0, 0);
    #2;
    chk("to.fired", timeout_o, 1);
    step("to_blocked", 1, rnd_cmd(), 1, 0, 0);
    step("to_late_resp", 0, rnd_cmd(), 1, 1, 1);
    #2;
    chk("to.late_out", outstanding_o, 0);
    step("to_after", 1, rnd_cmd(), 1, 0, 0);

    // Randomized traffic in several segments
    for (int s = 0; s < 4; s++) begin
      do_reset("rnd_rst");
      for (int c = 0; c < 400; c++) begin
        bit cv, fr, rv, ry;
        cv = ($urandom % 4) != 0;
        fr = ($urandom % 4) != 0;
        rv = ($urandom % 2) != 0;
        if (m_out > 0) ry = ($urandom % 3) != 0;
        else ry = ($urandom % 64) == 0;
        step("rnd", cv, rnd_cmd(), fr, rv, ry);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
